// File: rtl/inst_rom_loader.sv
// Instruction ROM with a byte-serial run-time loader that holds the core in reset while loading.
// Optional feature: define INST_ROM_CHECKSUM_EN to build the running word checksum.
module inst_rom_loader #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rom_ce_i,
  input  logic [31:0]   rom_addr_i,
  output logic [31:0]   rom_data_o,
  input  logic          ld_start_i,
  input  logic          ld_valid_i,
  input  logic [7:0]    ld_data_i,
  output logic          ld_ready_o,
  input  logic          ld_done_i,
  output logic          cpu_rst_o,
  output logic [AW:0]   wcnt_o,
  output logic          err_o,
  output logic [31:0]   checksum_o
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t        state;
  logic [AW:0]   wcnt;
  logic [1:0]    bcnt;
  logic [23:0]   asm_word;
  logic          cpu_rst;
  logic          err;
  logic [31:0]   mem [DEPTH];

  logic          full;
  logic          hs;
  logic          word_we;
  logic          start_load;
  logic [31:0]   word;
  logic [AW-1:0] idx;
  logic          hit;
  logic          unused_addr_lsb;

  assign full       = (wcnt == (AW+1)'(DEPTH));
  assign ld_ready_o = (state == LOAD) && !full;
  assign hs         = ld_valid_i && ld_ready_o;
  assign word_we    = hs && (bcnt == 2'd3);
  assign start_load = ld_start_i && (state != LOAD);
  assign word       = {asm_word, ld_data_i};

  // Load/run controller; partial words at done are dropped and flagged.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cpu_rst  <= 1'b1;
      wcnt     <= '0;
      bcnt     <= '0;
      asm_word <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE, RUN: begin
          if (ld_start_i) begin
            state    <= LOAD;
            cpu_rst  <= 1'b1;
            wcnt     <= '0;
            bcnt     <= '0;
            asm_word <= '0;
            err      <= 1'b0;
          end
        end
        LOAD: begin
          if (hs) begin
            if (bcnt == 2'd3) begin
              wcnt <= wcnt + (AW+1)'(1);
              bcnt <= '0;
            end else begin
              asm_word <= {asm_word[15:0], ld_data_i};
              bcnt     <= bcnt + 2'd1;
            end
          end
          if (ld_done_i) begin
            state    <= RUN;
            cpu_rst  <= 1'b0;
            bcnt     <= '0;
            asm_word <= '0;
            if (hs ? (bcnt != 2'd3) : (bcnt != 2'd0)) err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Word array has no reset; unwritten entries stay unreachable behind wcnt.
  always_ff @(posedge clk) begin
    if (rst && word_we) mem[wcnt[AW-1:0]] <= word;
  end

`ifdef INST_ROM_CHECKSUM_EN
  logic [31:0] csum;

  always_ff @(posedge clk) begin
    if (!rst)            csum <= '0;
    else if (start_load) csum <= '0;
    else if (word_we)    csum <= csum + word;
  end

  assign checksum_o = csum;
`else
  assign checksum_o = 32'h0;
`endif

  // Zero-latency fetch; anything outside the loaded region reads as NOP.
  assign idx             = rom_addr_i[AW+1:2];
  assign hit             = rom_ce_i && (state == RUN) && (rom_addr_i[31:AW+2] == '0)
                           && ({1'b0, idx} < wcnt);
  assign rom_data_o      = hit ? mem[idx] : 32'h0;
  assign unused_addr_lsb = ^rom_addr_i[1:0];

  assign cpu_rst_o = cpu_rst;
  assign wcnt_o    = wcnt;
  assign err_o     = err;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: a 1024-word instance and a 4-word instance for the full case.
module tb_inst_rom_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ce;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        start, valid, done, ready, cpu_rst, err;
  logic [7:0]  data;
  logic [10:0] wcnt;
  logic [31:0] csum;

  logic        b_ce;
  logic [31:0] b_addr;
  logic [31:0] b_rdata;
  logic        b_start, b_valid, b_done, b_ready, b_cpu_rst, b_err;
  logic [7:0]  b_data;
  logic [2:0]  b_wcnt;
  logic [31:0] b_csum;

  int n_chk = 0;
  int n_fail = 0;

  inst_rom_loader #(.DEPTH(1024), .AW(10)) dut (
    .clk(clk), .rst(rst), .rom_ce_i(ce), .rom_addr_i(addr), .rom_data_o(rdata),
    .ld_start_i(start), .ld_valid_i(valid), .ld_data_i(data), .ld_ready_o(ready),
    .ld_done_i(done), .cpu_rst_o(cpu_rst), .wcnt_o(wcnt), .err_o(err), .checksum_o(csum)
  );

  inst_rom_loader #(.DEPTH(4), .AW(2)) dut_small (
    .clk(clk), .rst(rst), .rom_ce_i(b_ce), .rom_addr_i(b_addr), .rom_data_o(b_rdata),
    .ld_start_i(b_start), .ld_valid_i(b_valid), .ld_data_i(b_data), .ld_ready_o(b_ready),
    .ld_done_i(b_done), .cpu_rst_o(b_cpu_rst), .wcnt_o(b_wcnt), .err_o(b_err),
    .checksum_o(b_csum)
  );

  typedef struct {
    logic        ce;
    logic [31:0] addr;
    logic [31:0] exp;
  } fetch_vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    valid = 1'b1;
    data  = b;
    tick();
    valid = 1'b0;
  endtask

  task automatic fetch(input string name, input logic c, input logic [31:0] a,
                       input logic [31:0] exp);
    ce   = c;
    addr = a;
    #1;
    check(name, rdata, exp);
  endtask

  fetch_vec_t fv [8];
  logic [7:0] prog [8];
  int accepted;
  int first_stall;

  initial begin
    fv[0] = '{1'b1, 32'h0000_0000, 32'h3408_0005};
    fv[1] = '{1'b1, 32'h0000_0004, 32'h2402_000A};
    fv[2] = '{1'b1, 32'h0000_0008, 32'h0000_0000};
    fv[3] = '{1'b1, 32'h0000_0003, 32'h3408_0005};
    fv[4] = '{1'b1, 32'h0000_0006, 32'h2402_000A};
    fv[5] = '{1'b0, 32'h0000_0000, 32'h0000_0000};
    fv[6] = '{1'b1, 32'h1000_0000, 32'h0000_0000};
    fv[7] = '{1'b1, 32'h0000_1000, 32'h0000_0000};
    prog[0] = 8'h34; prog[1] = 8'h08; prog[2] = 8'h00; prog[3] = 8'h05;
    prog[4] = 8'h24; prog[5] = 8'h02; prog[6] = 8'h00; prog[7] = 8'h0A;

    rst = 1'b0; ce = 1'b0; addr = '0; start = 0; valid = 0; done = 0; data = '0;
    b_ce = 1'b0; b_addr = '0; b_start = 0; b_valid = 0; b_done = 0; b_data = '0;
    tick(); tick();
    rst = 1'b1;
    tick(); tick(); tick();

    check("reset_cpu_rst", 32'(cpu_rst), 32'd1);
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_wcnt", 32'(wcnt), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_csum", csum, 32'h0);
    fetch("reset_fetch", 1'b1, 32'h0, 32'h0);

    pulse_done();
    check("done_in_idle_ignored", 32'(cpu_rst), 32'd1);

    // Program 1: two full words
    pulse_start();
    check("load_ready", 32'(ready), 32'd1);
    check("load_cpu_rst", 32'(cpu_rst), 32'd1);
    for (int i = 0; i < 8; i++) send_byte(prog[i]);
    check("pre_done_cpu_rst", 32'(cpu_rst), 32'd1);
    pulse_done();
    check("p1_wcnt", 32'(wcnt), 32'd2);
    check("p1_err", 32'(err), 32'd0);
    check("p1_cpu_rst", 32'(cpu_rst), 32'd0);
    check("p1_ready", 32'(ready), 32'd0);
`ifdef INST_ROM_CHECKSUM_EN
    check("p1_csum", csum, 32'h580A_000F);
`else
    check("p1_csum", csum, 32'h0);
`endif
    for (int i = 0; i < 8; i++) fetch($sformatf("p1_fetch_%0d", i), fv[i].ce, fv[i].addr, fv[i].exp);

    // Program 2: one word plus two stray bytes
    pulse_start();
    check("p2_cpu_rst_rise", 32'(cpu_rst), 32'd1);
    fetch("p2_fetch_in_load", 1'b1, 32'h0, 32'h0);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66);
    pulse_done();
    check("p2_wcnt", 32'(wcnt), 32'd1);
    check("p2_err", 32'(err), 32'd1);
    fetch("p2_fetch0", 1'b1, 32'h0, 32'h1122_3344);
    fetch("p2_fetch4", 1'b1, 32'h4, 32'h0);
`ifdef INST_ROM_CHECKSUM_EN
    check("p2_csum", csum, 32'h1122_3344);
`endif

    // Done on the same edge as the 4th byte
    pulse_start();
    check("p3_err_cleared", 32'(err), 32'd0);
    check("p3_wcnt_cleared", 32'(wcnt), 32'd0);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    done = 1'b1;
    send_byte(8'hDD);
    done = 1'b0;
    check("p3_wcnt", 32'(wcnt), 32'd1);
    check("p3_err", 32'(err), 32'd0);
    check("p3_cpu_rst", 32'(cpu_rst), 32'd0);
    fetch("p3_fetch0", 1'b1, 32'h0, 32'hAABB_CCDD);

    // Reset in the middle of a load
    ce = 1'b0;
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(8'(i + 1));
    check("mid_wcnt_before_rst", 32'(wcnt), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst_wcnt", 32'(wcnt), 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_ready", 32'(ready), 32'd0);
    tick();
    check("rst_idle_ready", 32'(ready), 32'd0);

    pulse_start();
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    pulse_done();
    fetch("run_ce0", 1'b0, 32'h0, 32'h0);
    fetch("run_ce1", 1'b1, 32'h0, 32'hDEAD_BEEF);
    ce = 1'b0;

    // Small instance: fill to capacity with valid held
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    accepted = 0;
    first_stall = -1;
    b_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      b_data = 8'(i + 1);
      #1;
      if (b_ready) accepted++;
      else if (first_stall < 0) first_stall = i;
      tick();
    end
    b_valid = 1'b0;
    check("full_accepted", 32'(accepted), 32'd16);
    check("full_first_stall", 32'(first_stall), 32'd16);
    check("full_wcnt", 32'(b_wcnt), 32'd4);
    check("full_ready", 32'(b_ready), 32'd0);
    b_done = 1'b1;
    tick();
    b_done = 1'b0;
    check("full_err", 32'(b_err), 32'd0);
    check("full_cpu_rst", 32'(b_cpu_rst), 32'd0);
    b_ce = 1'b1;
    b_addr = 32'h0;
    #1;
    check("full_fetch0", b_rdata, 32'h0102_0304);
    b_addr = 32'hC;
    #1;
    check("full_fetch12", b_rdata, 32'h0D0E_0F10);
    b_addr = 32'h10;
    #1;
    check("full_fetch16", b_rdata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_rom_loader.md
# inst_rom_loader

Instruction-memory responder for the CPU's fetch interface: answers the core's `rom_ce`/`rom_addr` requests with 32-bit instruction words from an internal word array. The array is filled at run time from a byte-serial load port with a valid/ready handshake. A load/run state machine holds the core in reset (`cpu_rst_o`) while a program is streamed in. It sits beside the CPU top, driving the core's `rom_data_i` and reset.

## Interface
Parameters:
- `DEPTH`, 1024 — instruction words stored; power of two.
- `AW`, 10 — word-index width, log2(`DEPTH`).

Ports:
- `clk` in 1 — single clock; all state updates on the rising edge.
- `rst` in 1 — synchronous, active-low reset.
- `rom_ce_i` in 1 — fetch enable from the core.
- `rom_addr_i` in 32 — byte address from the core.
- `rom_data_o` out 32 — instruction word to the core; combinational.
- `ld_start_i` in 1 — one-cycle pulse that begins a load.
- `ld_valid_i` in 1 — load byte valid.
- `ld_data_i` in 8 — load byte.
- `ld_ready_o` out 1 — loader can accept a byte.
- `ld_done_i` in 1 — one-cycle pulse that ends a load.
- `cpu_rst_o` out 1 — core reset; 1 while the core is held.
- `wcnt_o` out AW+1 — number of complete words loaded.
- `err_o` out 1 — sticky; last load ended with a partial word.
- `checksum_o` out 32 — running word sum (see Configuration).

## Operation
- States: IDLE (after reset), LOAD, RUN.
  - IDLE → LOAD on `ld_start_i`.
  - LOAD → RUN on `ld_done_i`.
  - RUN → LOAD on `ld_start_i`.
  - `ld_done_i` is ignored outside LOAD.
  - `ld_start_i` is ignored in LOAD.
- `cpu_rst_o` is 1 in IDLE and LOAD and 0 in RUN. It is registered from the state.
- Entering LOAD:
  - clears `wcnt_o`, the byte counter, the word assembler, `err_o` and the checksum;
  - does not clear the array.
- Byte assembly:
  - Bytes are big-endian. The first byte of a word goes to [31:24] and the fourth to [7:0].
  - On the edge that accepts the 4th byte, the complete word is written to array[`wcnt_o`] and `wcnt_o` increments.
- Full condition: `wcnt_o` == `DEPTH` forces `ld_ready_o` to 0. Offered bytes are not consumed, and nothing wraps.
- `ld_ready_o` = (state==LOAD) && !full.
- Fetch, with idx = `rom_addr_i[AW+1:2]`:
  - `rom_data_o` = array[idx] when `rom_ce_i`, state==RUN, `rom_addr_i[31:AW+2]`==0 and idx < `wcnt_o`.
  - Otherwise `rom_data_o` = 32'h0 (a NOP).
  - `rom_addr_i[1:0]` is ignored.
- `ld_done_i` with a non-zero byte count:
  - the partial bytes are discarded;
  - `err_o` is set and stays set until the next `ld_start_i`;
  - the state still goes to RUN.
- `ld_done_i` on the same edge as the handshake of a word's 4th byte: the word is written and counted first, then the state goes to RUN, with no error.
- Reset values:
  - state IDLE;
  - `cpu_rst_o` 1, `ld_ready_o` 0, `rom_data_o` 0;
  - `wcnt_o` 0, `err_o` 0, `checksum_o` 0.
  - Array contents are undefined but unreachable, because `wcnt_o` is 0.
- `rst` asserted mid-load aborts the load and returns to IDLE on that edge.

## Timing
- A handshake is `ld_valid_i && ld_ready_o` sampled at the rising edge. One byte can be accepted per cycle.
- A word is readable by fetch from the cycle after its 4th-byte edge, once the state is RUN.
- `ld_ready_o` rises the cycle after the `ld_start_i` edge and falls the cycle after the `ld_done_i` edge.
- `cpu_rst_o` falls the cycle after the `ld_done_i` edge and rises the cycle after the `ld_start_i` edge.
- Fetch read latency is zero (combinational). This matches the core latching `rom_data_i` at the same edge that registers the PC.

## Configuration
- `INST_ROM_CHECKSUM_EN` defined:
  - `checksum_o` is a 32-bit modulo-2^32 sum of every word written during the current load;
  - it updates on the word-write edge and clears on `ld_start_i`.
- Not defined: `checksum_o` is tied to 32'h0 and no adder is built.

## Test plan
- Reset, then 3 idle cycles → `cpu_rst_o`=1, `ld_ready_o`=0, `wcnt_o`=0, and `rom_data_o`=0 for `rom_addr_i`=0 with `rom_ce_i`=1.
- `ld_start_i`; bytes 34 08 00 05 24 02 00 0A; `ld_done_i` → `wcnt_o`=2, `err_o`=0, `cpu_rst_o` falls the next cycle. Fetch at addr 0 gives 32'h34080005, addr 4 gives 32'h2402000A, addr 8 gives 0. With the macro, `checksum_o`=32'h580A000F.
- `ld_start_i`; bytes 11 22 33 44 55 66; `ld_done_i` → `wcnt_o`=1, `err_o`=1, addr 0 gives 32'h11223344, addr 4 gives 0.
- DEPTH=4 with 20 bytes offered back-to-back and `ld_valid_i` held → `ld_ready_o` drops after byte 16, `wcnt_o`=4, and bytes 17–20 are not consumed.
- `ld_done_i` on the same edge as a 4th byte → the word is counted and `err_o`=0.
- Assert `rst` mid-load after 6 bytes → state IDLE, `wcnt_o`=0, `cpu_rst_o`=1. In RUN, fetch with `rom_ce_i`=0 → `rom_data_o`=0.
